// File: rtl/button_mode_if.sv
// Button-to-mode-controller link: debounced level in, event pulses and mode index out.
interface button_mode_if #(
  parameter int MODE_W = 3
);
  logic              pb_debounce;
  logic              press_pulse;
  logic              short_pulse;
  logic              long_pulse;
  logic [MODE_W-1:0] mode;

  modport master (output pb_debounce, input press_pulse, short_pulse, long_pulse, mode);
  modport slave  (input pb_debounce, output press_pulse, short_pulse, long_pulse, mode);
endinterface

// File: rtl/button_mode_ctrl.sv
// Press interpreter: turns the debounced button level into press/short/long pulses
// and keeps the display-mode index (short press advances, long press returns to 0).
module button_mode_ctrl #(
  parameter int LONG_CYCLES = 1000,
  parameter int NUM_MODES   = 8,
  parameter int MODE_W      = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  button_mode_if.slave bus
);
  localparam int CW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0]     LONG_C   = CW'(LONG_CYCLES);
  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  state_t            state;
  logic              pb_prev;
  logic [CW-1:0]     hold_cnt;
  logic [MODE_W-1:0] mode_q;
  logic              press_q, short_q, long_q;
  logic              pb, rise;

  assign pb   = bus.pb_debounce;
  assign rise = pb & ~pb_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // pb_prev starts high so a button held through reset is not taken as a press
      pb_prev  <= 1'b1;
      state    <= IDLE;
      hold_cnt <= '0;
      mode_q   <= '0;
      press_q  <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      pb_prev <= pb;
      press_q <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state    <= PRESSED;
            hold_cnt <= CW'(1);
            press_q  <= 1'b1;
          end
        end
        PRESSED: begin
          if (pb) begin
            if (hold_cnt + CW'(1) == LONG_C) begin
              hold_cnt <= LONG_C;
              long_q   <= 1'b1;
              mode_q   <= '0;
              state    <= HELD;
            end else begin
              hold_cnt <= hold_cnt + CW'(1);
            end
          end else begin
            short_q <= 1'b1;
            mode_q  <= (mode_q == MODE_MAX) ? '0 : mode_q + MODE_W'(1);
            state   <= IDLE;
          end
        end
        HELD: begin
          // count stays saturated; the release is silent since the long press was reported
          if (!pb) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.press_pulse = press_q;
  assign bus.short_pulse = short_q;
  assign bus.long_pulse  = long_q;
  assign bus.mode        = mode_q;
endmodule
